// File: rtl/mips_pkg.sv
// Shared MIPS core constants: reset PC, NOP encoding, opcode field position,
// fetch FSM encoding and the fetch packet carried through the skid buffer.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fetchPkt_t;

  // Branch targets are always word aligned; low bits are dropped.
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and live flag, with
// flush > load > bubble > hold priority below synchronous reset.
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            bubble,
  input  fetchPkt_t       pktIn,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= pktIn.instr;
      pc4   <= pktIn.pc4;
      valid <= 1'b1;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/valid handshake, 1-entry skid buffer
// and IF/ID register. Optional perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_valid,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [DATA_WIDTH-1:0] if_id_pc4,
  output logic                  if_id_valid,
  output logic [OPCODE_W-1:0]   opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  logic [STATE_W-1:0] stateReg, stateNext;
  logic [XLEN-1:0]    pcReg, pcNext, pcPlus4;
  logic [XLEN-1:0]    addrReg, addrNext;
  logic               reqReg, reqNext;
  logic               skidValid, skidValidNext;
  fetchPkt_t          skidPkt, skidPktNext, idPkt;
  logic               idLoad, idFlush, idBubble;
  logic               memDone;

  assign pcPlus4   = pcReg + 32'd4;
  assign memDone   = reqReg && imem_valid;
  assign imem_req  = reqReg;
  assign imem_addr = addrReg;
  assign opcode    = if_id_instr[OPCODE_MSB:OPCODE_LSB];

  // Next-state, PC, skid and IF/ID control decode.
  always_comb begin
    stateNext     = stateReg;
    pcNext        = pcReg;
    skidValidNext = skidValid;
    skidPktNext   = skidPkt;
    idLoad        = 1'b0;
    idFlush       = 1'b0;
    idBubble      = 1'b0;
    idPkt         = '{instr: imem_rdata, pc4: pcPlus4};

    if (branch_taken) begin
      // Redirect beats stall; an in-flight request must still be drained.
      pcNext        = alignWord(branch_target);
      idFlush       = 1'b1;
      skidValidNext = 1'b0;
      stateNext     = (reqReg && !imem_valid) ? DRAIN : ISSUE;
    end else begin
      case (stateReg)
        ISSUE: begin
          if (memDone) begin
            pcNext = pcPlus4;
            if (stall) begin
              skidValidNext = 1'b1;
              skidPktNext   = idPkt;
              stateNext     = HOLD;
            end else begin
              idLoad = 1'b1;
            end
          end else if (!stall) begin
            idBubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            idLoad        = skidValid;
            idPkt         = skidPkt;
            skidValidNext = 1'b0;
            stateNext     = ISSUE;
          end
        end
        DRAIN: begin
          if (imem_valid) stateNext = ISSUE;
        end
        default: stateNext = ISSUE;
      endcase
    end

    // Request stays on the stale address while draining.
    reqNext  = (stateNext != HOLD);
    addrNext = (stateNext == DRAIN) ? addrReg : pcNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg  <= ISSUE;
      pcReg     <= PC_RESET;
      reqReg    <= 1'b0;
      addrReg   <= PC_RESET;
      skidValid <= 1'b0;
      skidPkt   <= '0;
    end else begin
      stateReg  <= stateNext;
      pcReg     <= pcNext;
      reqReg    <= reqNext;
      addrReg   <= addrNext;
      skidValid <= skidValidNext;
      skidPkt   <= skidPktNext;
    end
  end

  if_id_reg uIfId (
    .clk    (clk),
    .reset  (reset),
    .load   (idLoad),
    .flush  (idFlush),
    .bubble (idBubble),
    .pktIn  (idPkt),
    .instr  (if_id_instr),
    .pc4    (if_id_pc4),
    .valid  (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  // Accepted-instruction and stalled-live-instruction counters, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (idLoad) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && if_id_valid) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, drain/reset sequences, and
// randomized traffic against a transaction-level reference model.
module tb_fetch_stage;
  import mips_pkg::*;

  localparam logic [31:0] PCR = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req, imem_valid, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
  logic [5:0]  opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int memLat = 1;
  int memCnt = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .opcode        (opcode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  // Instruction memory contents: a few fixed words, hashed elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h2008_0005;
      32'h0040_0004: return 32'h3509_00FF;
      32'h0040_0008: return 32'h1000_0003;
      default:       return ~a ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Memory answers in the memLat-th cycle of a held request.
  always @(posedge clk) begin
    if (reset || !imem_req || imem_valid) memCnt <= 0;
    else memCnt <= memCnt + 1;
  end
  assign imem_valid = imem_req && (memCnt >= memLat - 1);
  assign imem_rdata = memWord(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next fetch address, pending skid entries, discard flag.
  logic        mReq = 1'b0;
  logic [31:0] mAddr = PCR;
  logic [31:0] mPc = PCR;
  logic [31:0] mInstr = 32'h0;
  logic [31:0] mPc4 = 32'h0;
  logic        mValid = 1'b0;
  logic        mDiscard = 1'b0;
  logic [63:0] mSkid[$];
  logic [63:0] e;
  logic        took;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] mFetch = 32'h0;
  logic [31:0] mStall = 32'h0;
`endif

  always @(negedge clk) begin
    check("m_req", 32'(imem_req), 32'(mReq));
    if (mReq) check("m_addr", imem_addr, mAddr);
    check("m_valid", 32'(if_id_valid), 32'(mValid));
    check("m_instr", if_id_instr, mInstr);
    check("m_pc4", if_id_pc4, mPc4);
    check("m_opcode", 32'(opcode), 32'(mInstr >> 26));
`ifdef FETCH_PERF_CNT_EN
    check("m_fetch_cnt", fetch_cnt, mFetch);
    check("m_stall_cnt", stall_cnt, mStall);
`endif
    if (reset) begin
      mPc = PCR; mReq = 1'b0; mAddr = PCR; mDiscard = 1'b0; mSkid.delete();
      mValid = 1'b0; mInstr = NOP_INSTR; mPc4 = 32'h0;
`ifdef FETCH_PERF_CNT_EN
      mFetch = 32'h0; mStall = 32'h0;
`endif
    end else begin
`ifdef FETCH_PERF_CNT_EN
      if (stall && mValid) mStall = mStall + 32'd1;
`endif
      took = mReq && imem_valid;
      if (branch_taken) begin
        mDiscard = mReq && !imem_valid;
        mPc = branch_target & ~32'd3;
        mValid = 1'b0;
        mInstr = NOP_INSTR;
        mSkid.delete();
      end else if (mDiscard) begin
        if (imem_valid) mDiscard = 1'b0;
      end else if (mSkid.size() != 0) begin
        if (!stall) begin
          e = mSkid.pop_front();
          mInstr = e[63:32]; mPc4 = e[31:0]; mValid = 1'b1;
`ifdef FETCH_PERF_CNT_EN
          mFetch = mFetch + 32'd1;
`endif
        end
      end else if (took) begin
        if (stall) mSkid.push_back({imem_rdata, mPc + 32'd4});
        else begin
          mInstr = imem_rdata; mPc4 = mPc + 32'd4; mValid = 1'b1;
`ifdef FETCH_PERF_CNT_EN
          mFetch = mFetch + 32'd1;
`endif
        end
        mPc = mPc + 32'd4;
      end else if (!stall) begin
        mValid = 1'b0;
      end
      mReq = (mSkid.size() == 0);
      if (!mDiscard) mAddr = mPc;
    end
  end

  typedef struct {
    logic        rst, stl, br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr, pc4;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] firstNew, ei;
  logic        got;

  initial begin
    vecs[0]  = '{1, 0, 0, 32'h0,         0, PCR,           0, 32'h0,         32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,         1, PCR,           0, 32'h0,         32'h0};
    vecs[2]  = '{0, 0, 0, 32'h0,         1, 32'h0040_0004, 1, 32'h2008_0005, 32'h0040_0004};
    vecs[3]  = '{0, 0, 0, 32'h0,         1, 32'h0040_0008, 1, 32'h3509_00FF, 32'h0040_0008};
    vecs[4]  = '{0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h3509_00FF, 32'h0040_0008};
    vecs[5]  = '{0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h3509_00FF, 32'h0040_0008};
    vecs[6]  = '{0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h3509_00FF, 32'h0040_0008};
    vecs[7]  = '{0, 0, 0, 32'h0,         1, 32'h0040_000C, 1, 32'h1000_0003, 32'h0040_000C};
    vecs[8]  = '{0, 0, 0, 32'h0,         1, 32'h0040_0010, 1, memWord(32'h0040_000C), 32'h0040_0010};
    vecs[9]  = '{0, 1, 1, 32'h0040_0103, 1, 32'h0040_0100, 0, 32'h0,         32'h0040_0010};
    vecs[10] = '{0, 0, 0, 32'h0,         1, 32'h0040_0104, 1, memWord(32'h0040_0100), 32'h0040_0104};
    vecs[11] = '{0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0040_0104};
    vecs[12] = '{0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, memWord(32'hFFFF_FFFC), 32'h0000_0000};

    memLat = 1;
    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst; stall = vecs[i].stl;
      branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      @(posedge clk); #1;
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      if (vecs[i].req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("vec%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].vld));
      check($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].instr);
      check($sformatf("vec%0d_pc4", i), if_id_pc4, vecs[i].pc4);
      ei = vecs[i].instr;
      check($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(ei[31:26]));
    end
    stall = 1'b0; branch_taken = 1'b0;

    // Redirect while a 3-cycle request is outstanding: stale data dropped.
    memLat = 3; branch_taken = 1'b1; branch_target = 32'h0040_0103;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    check("drain_req", 32'(imem_req), 32'd1);
    check("drain_old_addr", imem_addr, 32'h0);
    check("drain_flush", 32'(if_id_valid), 32'd0);
    got = 1'b0; firstNew = 32'hDEAD_DEAD;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk); #1;
      if (firstNew == 32'hDEAD_DEAD && imem_addr != 32'h0) firstNew = imem_addr;
      if (if_id_valid) got = 1'b1;
    end
    check("drain_done", 32'(got), 32'd1);
    check("drain_new_addr", firstNew, 32'h0040_0100);
    check("drain_instr", if_id_instr, memWord(32'h0040_0100));
    check("drain_pc4", if_id_pc4, 32'h0040_0104);

    // Reset in the middle of an outstanding request.
    memLat = 6;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midreq_req", 32'(imem_req), 32'd1);
    check("midreq_novalid", 32'(imem_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    @(posedge clk); #1;
    check("rst_pc", imem_addr, PCR);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // Randomized traffic; the reference model checks every cycle.
    repeat (3000) begin
      reset = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_target = $urandom;
      if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      memLat = $urandom_range(1, 4);
      @(posedge clk); #1;
    end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
